// File: rtl/alu_req_arbiter_if.sv
// Requester, ALU-control and response signals of the two-requester ALU arbiter.
// The master side is the environment (requesters, ALU datapath, response consumer);
// the slave side is the arbiter itself.
interface alu_req_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_mode;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_mode;
    logic [1:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              alu_enable;
    logic              alu_enable_a;
    logic              alu_enable_b;
    logic [1:0]        alu_op_a;
    logic [1:0]        alu_op_b;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_c;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_mode, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_mode, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_a, alu_b,
        output alu_c,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_mode, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_mode, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_a, alu_b,
        input  alu_c,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. A granted command
// is captured in IDLE, drives the ALU control lines for ALU_LAT+1 cycles in EXEC,
// and its captured result is offered in RESP until the consumer takes it.
// Illegal mode encodings skip EXEC and return an error response.
module alu_req_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_req_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int                CNT_W    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALU_LAT);
    localparam logic [2:0]        MODE_A   = 3'b101;
    localparam logic [2:0]        MODE_B   = 3'b011;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [2:0]         mode_q, mode_d;
    logic [1:0]         op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic               any_valid;
    logic               grant_id;
    logic [2:0]         sel_mode;
    logic [1:0]         sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic               sel_legal;
    logic               ready0, ready1;

    // Round-robin choice between pending requesters and selection of that requester's command
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
        if (grant_id) begin
            sel_mode = bus.req1_mode;
            sel_op   = bus.req1_op;
            sel_a    = bus.req1_a;
            sel_b    = bus.req1_b;
        end else begin
            sel_mode = bus.req0_mode;
            sel_op   = bus.req0_op;
            sel_a    = bus.req0_a;
            sel_b    = bus.req0_b;
        end
        sel_legal = (sel_mode == MODE_A) || (sel_mode == MODE_B);
    end

    // State, command capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mode_q       <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state logic: accept in IDLE, count ALU latency in EXEC, hand off in RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mode_d       = mode_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        ready0       = 1'b0;
        ready1       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready0   = ~grant_id;
                    ready1   = grant_id;
                    mode_d   = sel_mode;
                    op_d     = sel_op;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    rsp_id_d = grant_id;
                    cnt_d    = '0;
                    if (sel_legal) begin
                        state_d = EXEC;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = bus.alu_c;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output drive: ALU lines are live only in EXEC, so reset clears them without a clock
    always_comb begin
        bus.req0_ready   = ready0;
        bus.req1_ready   = ready1;
        bus.alu_enable   = (state_q == EXEC);
        bus.alu_enable_a = (state_q == EXEC) && mode_q[2];
        bus.alu_enable_b = (state_q == EXEC) && mode_q[1];
        bus.alu_op_a     = '0;
        bus.alu_op_b     = '0;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        if (state_q == EXEC) begin
            bus.alu_a = a_q;
            bus.alu_b = b_q;
            if (mode_q == MODE_A) begin
                bus.alu_op_a = op_q;
            end else begin
                bus.alu_op_b = op_q;
            end
        end
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_id    = rsp_id_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a registered ALU model (ALU_LAT=1),
// a per-cycle behavioural reference and literal expectations per scenario.
module tb_alu_req_arbiter;
    localparam int DATA_W  = 8;
    localparam int ALU_LAT = 1;

    logic clk;
    logic rst_n;

    alu_req_arbiter_if #(.DATA_W(DATA_W)) bus ();

    alu_req_arbiter #(.DATA_W(DATA_W), .ALU_LAT(ALU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of a command, straight from the opcode tables
    function automatic logic [7:0] ref_result(input logic [2:0] mode, input logic [1:0] op,
                                              input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (mode == 3'b101) begin
            case (op)
                2'd0: r = a & b;
                2'd1: r = ~(a & b);
                2'd2: r = a | b;
                2'd3: r = a ^ b;
            endcase
        end else if (mode == 3'b011) begin
            case (op)
                2'd0: r = ~(a ^ b);
                2'd1: r = a & b;
                2'd2: r = ~(a | b);
                2'd3: r = a | b;
            endcase
        end
        return r;
    endfunction

    // Environment ALU with one cycle of output latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_c <= 8'h00;
        end else if (bus.alu_enable && bus.alu_enable_a) begin
            case (bus.alu_op_a)
                2'd0: bus.alu_c <= bus.alu_a & bus.alu_b;
                2'd1: bus.alu_c <= ~(bus.alu_a & bus.alu_b);
                2'd2: bus.alu_c <= bus.alu_a | bus.alu_b;
                default: bus.alu_c <= bus.alu_a ^ bus.alu_b;
            endcase
        end else if (bus.alu_enable && bus.alu_enable_b) begin
            case (bus.alu_op_b)
                2'd0: bus.alu_c <= ~(bus.alu_a ^ bus.alu_b);
                2'd1: bus.alu_c <= bus.alu_a & bus.alu_b;
                2'd2: bus.alu_c <= ~(bus.alu_a | bus.alu_b);
                default: bus.alu_c <= bus.alu_a | bus.alu_b;
            endcase
        end else begin
            bus.alu_c <= 8'h00;
        end
    end

    // Reference model: phase 0 waiting, 1 ALU busy, 2 response offered
    int         m_phase = 0;
    int         m_left  = 0;
    logic       m_last  = 1'b1;
    logic       m_id;
    logic [2:0] m_mode;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b, m_data;
    logic       m_err;
    int         grant_log[$];
    int         en_cycles = 0;

    // Compare DUT against the model every falling edge, then advance the model past the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_last  = 1'b1;
            chk("rst_alu_enable", bus.alu_enable, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        end else begin
            if (bus.alu_enable) en_cycles++;
            case (m_phase)
                0: begin
                    logic g;
                    logic any;
                    any = bus.req0_valid || bus.req1_valid;
                    g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
                    chk("idle_ready0", bus.req0_ready, any && !g);
                    chk("idle_ready1", bus.req1_ready, any && g);
                    chk("idle_alu_enable", bus.alu_enable, 0);
                    chk("idle_rsp_valid", bus.rsp_valid, 0);
                    if (any) begin
                        grant_log.push_back(int'(g));
                        m_id   = g;
                        m_mode = g ? bus.req1_mode : bus.req0_mode;
                        m_op   = g ? bus.req1_op   : bus.req0_op;
                        m_a    = g ? bus.req1_a    : bus.req0_a;
                        m_b    = g ? bus.req1_b    : bus.req0_b;
                        if (m_mode == 3'b101 || m_mode == 3'b011) begin
                            m_data  = ref_result(m_mode, m_op, m_a, m_b);
                            m_err   = 1'b0;
                            m_left  = ALU_LAT + 1;
                            m_phase = 1;
                        end else begin
                            m_data  = 8'h00;
                            m_err   = 1'b1;
                            m_phase = 2;
                        end
                    end
                end
                1: begin
                    logic is_a;
                    is_a = (m_mode == 3'b101);
                    chk("exec_alu_enable", bus.alu_enable, 1);
                    chk("exec_enable_a", bus.alu_enable_a, is_a);
                    chk("exec_enable_b", bus.alu_enable_b, !is_a);
                    chk("exec_op_a", bus.alu_op_a, is_a ? m_op : 2'b00);
                    chk("exec_op_b", bus.alu_op_b, is_a ? 2'b00 : m_op);
                    chk("exec_alu_a", bus.alu_a, m_a);
                    chk("exec_alu_b", bus.alu_b, m_b);
                    chk("exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
                    chk("exec_rsp_valid", bus.rsp_valid, 0);
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: begin
                    chk("resp_valid", bus.rsp_valid, 1);
                    chk("resp_id", bus.rsp_id, m_id);
                    chk("resp_data", bus.rsp_data, m_data);
                    chk("resp_err", bus.rsp_err, m_err);
                    chk("resp_ready", {bus.req0_ready, bus.req1_ready}, 0);
                    chk("resp_alu_enable", bus.alu_enable, 0);
                    if (bus.rsp_ready) begin
                        m_last  = m_id;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic drive_req(input int id, input logic v, input logic [2:0] mode,
                             input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_mode = mode; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_mode = mode; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Present a command until accepted (bounded), then withdraw it just after the accept edge
    task automatic send(input int id, input logic [2:0] mode, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b);
        bit acc;
        acc = 0;
        drive_req(id, 1'b1, mode, op, a, b);
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) acc = 1;
        end
        chk("accept_timeout", acc, 1);
        @(posedge clk); #1;
        drive_req(id, 1'b0, mode, op, a, b);
    endtask

    // Wait (bounded) for a response and sample it on a falling edge
    task automatic wait_rsp(output logic id, output logic [7:0] data, output logic err);
        bit seen;
        seen = 0;
        id = 1'b0; data = 8'h00; err = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1; id = bus.rsp_id; data = bus.rsp_data; err = bus.rsp_err;
            end
        end
        chk("rsp_timeout", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rid, rerr;
        logic [7:0] rdata;
        int         base;
        int         acc_before;

        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(0, 1'b0, 3'b000, 2'b00, 8'h00, 8'h00);
        drive_req(1, 1'b0, 3'b000, 2'b00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("pin_ref_and", ref_result(3'b101, 2'b00, 8'hF0, 8'h3C), 32'h30);
        chk("pin_ref_nor", ref_result(3'b011, 2'b10, 8'h0F, 8'hF0), 32'h00);
        @(posedge clk); #1;

        // Group A and: 0xF0 & 0x3C
        en_cycles = 0;
        send(0, 3'b101, 2'b00, 8'hF0, 8'h3C);
        wait_rsp(rid, rdata, rerr);
        chk("t1_id", rid, 0);
        chk("t1_data", rdata, 32'h30);
        chk("t1_err", rerr, 0);
        chk("t1_exec_cycles", en_cycles, 2);
        @(posedge clk); #1;

        // Group B nor: ~(0x0F | 0xF0)
        send(1, 3'b011, 2'b10, 8'h0F, 8'hF0);
        wait_rsp(rid, rdata, rerr);
        chk("t2_id", rid, 1);
        chk("t2_data", rdata, 32'h00);
        chk("t2_err", rerr, 0);
        @(posedge clk); #1;

        // Both requesters continuously valid for four grants
        base = grant_log.size();
        drive_req(0, 1'b1, 3'b101, 2'b11, 8'h55, 8'hFF);
        drive_req(1, 1'b1, 3'b011, 2'b01, 8'h0F, 8'h3C);
        for (int i = 0; i < 60 && grant_log.size() < base + 4; i++) @(negedge clk);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'b101, 2'b11, 8'h55, 8'hFF);
        drive_req(1, 1'b0, 3'b011, 2'b01, 8'h0F, 8'h3C);
        repeat (8) @(posedge clk); #1;
        chk("rr_count", grant_log.size() >= base + 4, 1);
        if (grant_log.size() >= base + 4) begin
            chk("rr_g0", grant_log[base],     0);
            chk("rr_g1", grant_log[base + 1], 1);
            chk("rr_g2", grant_log[base + 2], 0);
            chk("rr_g3", grant_log[base + 3], 1);
        end

        // Illegal mode: error response one cycle after accept, ALU untouched
        en_cycles = 0;
        send(0, 3'b000, 2'b01, 8'hAA, 8'h55);
        @(negedge clk);
        chk("ill_valid", bus.rsp_valid, 1);
        chk("ill_err", bus.rsp_err, 1);
        chk("ill_data", bus.rsp_data, 32'h00);
        chk("ill_id", bus.rsp_id, 0);
        chk("ill_no_alu", en_cycles, 0);
        @(posedge clk); #1;

        // Response stalled five cycles with a competing request pending
        bus.rsp_ready = 1'b0;
        send(1, 3'b101, 2'b01, 8'hFF, 8'h0F);
        drive_req(0, 1'b1, 3'b011, 2'b11, 8'h12, 8'h40);
        wait_rsp(rid, rdata, rerr);
        chk("st_first_data", rdata, 32'hF0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_valid", bus.rsp_valid, 1);
            chk("st_data", bus.rsp_data, 32'hF0);
            chk("st_id", bus.rsp_id, 1);
            chk("st_req0_ready", bus.req0_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("st_drain_valid", bus.rsp_valid, 1);
        @(posedge clk); #1;
        send(0, 3'b011, 2'b11, 8'h12, 8'h40);
        wait_rsp(rid, rdata, rerr);
        chk("st_next_id", rid, 0);
        chk("st_next_data", rdata, 32'h52);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of EXEC
        send(0, 3'b101, 2'b10, 8'h01, 8'h02);
        chk("rs_in_exec", bus.alu_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_alu_enable", bus.alu_enable, 0);
        chk("rs_enable_a", bus.alu_enable_a, 0);
        chk("rs_alu_a", bus.alu_a, 0);
        chk("rs_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_before = grant_log.size();
        drive_req(0, 1'b1, 3'b101, 2'b00, 8'hAA, 8'h0F);
        drive_req(1, 1'b1, 3'b011, 2'b00, 8'hAA, 8'hAA);
        for (int i = 0; i < 20 && grant_log.size() == acc_before; i++) @(negedge clk);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'b101, 2'b00, 8'hAA, 8'h0F);
        drive_req(1, 1'b0, 3'b011, 2'b00, 8'hAA, 8'hAA);
        wait_rsp(rid, rdata, rerr);
        chk("rs_winner", rid, 0);
        chk("rs_data", rdata, 32'h0A);
        chk("rs_err", rerr, 0);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
